// File: rtl/fir_axi_pkg.sv
// Shared types and constants for the AXI4-Lite port into the FIR sample memory.
`timescale 1ns/1ps
package fir_axi_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam int unsigned DefAddrW = 13;
  localparam int unsigned DefDataW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdWait,
    StRdResp
  } state_e;

endpackage

// File: rtl/axi_sample_port.sv
// AXI4-Lite responder turning host reads/writes into single-word sample-memory accesses
// arbitrated by the FIR control FSM through mem_req/mem_gnt.
`timescale 1ns/1ps
module axi_sample_port
  import fir_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = 8192,
  parameter int unsigned AXI_AW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AXI_AW-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [AXI_AW-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] a_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e state_q, state_d;
  logic   rd_prio_q;  // 1: read wins the next collision
  logic   oor_q;
  logic   [ADDR_W-1:0] addr_q;
  logic   [DATA_W-1:0] wdata_q;
  logic   [31:0]       rdata_q;
  logic   [1:0]        bresp_q, rresp_q;

  logic wr_cand, rd_cand, take_wr, take_rd;

  function automatic logic out_of_range(input logic [AXI_AW-1:0] byte_addr);
    return 32'(byte_addr[AXI_AW-1:2]) >= DEPTH;
  endfunction

  logic unused_bits;
  assign unused_bits = ^{s_wstrb, s_wdata[31:DATA_W], s_awaddr[1:0], s_araddr[1:0]};

  assign wr_cand = s_awvalid & s_wvalid;
  assign rd_cand = s_arvalid;
  assign take_wr = (state_q == StIdle) & wr_cand & (~rd_cand | ~rd_prio_q);
  assign take_rd = (state_q == StIdle) & rd_cand & (~wr_cand | rd_prio_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (take_wr)      state_d = StWrReq;
        else if (take_rd) state_d = StRdReq;
      end
      StWrReq:  if (oor_q || mem_gnt) state_d = StWrResp;
      StWrResp: if (s_bready) state_d = StIdle;
      StRdReq: begin
        if (oor_q)        state_d = StRdResp;
        else if (mem_gnt) state_d = StRdWait;
      end
      StRdWait: state_d = StRdResp;
      StRdResp: if (s_rready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    s_awready = take_wr;
    s_wready  = take_wr;
    s_arready = take_rd;
    s_bvalid  = (state_q == StWrResp);
    s_rvalid  = (state_q == StRdResp);
    mem_req   = ((state_q == StWrReq) || (state_q == StRdReq)) && !oor_q;
    mem_we    = (state_q == StWrReq) && !oor_q && mem_gnt;
  end

  // Datapath: latched address/data, arbitration pointer and responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_prio_q <= 1'b0;
      oor_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bresp_q   <= RespOkay;
      rresp_q   <= RespOkay;
    end else begin
      if (take_wr) begin
        addr_q    <= s_awaddr[ADDR_W+1:2];
        wdata_q   <= s_wdata[DATA_W-1:0];
        oor_q     <= out_of_range(s_awaddr);
        rd_prio_q <= 1'b1;
      end else if (take_rd) begin
        addr_q    <= s_araddr[ADDR_W+1:2];
        oor_q     <= out_of_range(s_araddr);
        rd_prio_q <= 1'b0;
      end
      if (state_q == StWrReq && (oor_q || mem_gnt)) begin
        bresp_q <= oor_q ? RespSlverr : RespOkay;
      end
      if (state_q == StRdReq && oor_q) begin
        rdata_q <= '0;
        rresp_q <= RespSlverr;
      end
      if (state_q == StRdWait) begin
        rdata_q <= 32'(mem_rdata);
        rresp_q <= RespOkay;
      end
    end
  end

  assign a_address = addr_q;
  assign mem_wdata = wdata_q;
  assign s_rdata   = rdata_q;
  assign s_bresp   = bresp_q;
  assign s_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_sample_port.sv
// Scoreboard bench for axi_sample_port with a behavioural 1-cycle-latency sample memory.
`timescale 1ns/1ps
module tb_axi_sample_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic        mem_req, mem_gnt, mem_we;
  logic [12:0] a_address;
  logic [15:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  axi_sample_port dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .a_address(a_address),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit          rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;
  typedef struct {
    logic [12:0] addr;
    logic [15:0] data;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   total = 0;
  int   bad = 0;
  int   req_count = 0;
  int   we_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample memory model: read data appears one cycle after the granted access.
  logic [15:0] mem [0:8191];
  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      if (mem_we) mem[a_address] <= mem_wdata;
      else        mem_rdata <= mem[a_address];
    end
  end

  // Monitor: memory writes and AXI responses against the scoreboard queues
  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    if (mem_req) req_count++;
    if (mem_we) begin
      we_count++;
      chk("we_with_req_gnt", {30'b0, mem_req, mem_gnt}, 32'd3);
      if (wr_q.size() == 0) chk("we_unexpected", 32'd1, 32'd0);
      else begin
        w = wr_q.pop_front();
        chk("we_addr", 32'(a_address), 32'(w.addr));
        chk("we_data", 32'(mem_wdata), 32'(w.data));
      end
    end
    if (s_bvalid && s_bready) begin
      if (rsp_q.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
      else begin
        r = rsp_q.pop_front();
        chk("b_order", 32'(r.rd), 32'd0);
        chk("bresp", 32'(s_bresp), 32'(r.resp));
      end
    end
    if (s_rvalid && s_rready) begin
      if (rsp_q.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
      else begin
        r = rsp_q.pop_front();
        chk("r_order", 32'(r.rd), 32'd1);
        chk("rresp", 32'(s_rresp), 32'(r.resp));
        chk("rdata", s_rdata, r.data);
      end
    end
  end

  function automatic rsp_t mk_rsp(input bit rd, input logic [1:0] resp, input logic [31:0] d);
    rsp_t r;
    r.rd = rd; r.resp = resp; r.data = d;
    return r;
  endfunction

  function automatic wr_t mk_wr(input logic [12:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    return w;
  endfunction

  // Each accept task returns 1 ns after the accepting clock edge.
  task automatic accept_write(input logic [15:0] addr, input logic [31:0] data);
    bit ok = 0;
    @(posedge clk); #1;
    s_awaddr = addr; s_wdata = data; s_awvalid = 1; s_wvalid = 1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (s_awready && s_wready) ok = 1;
    end
    if (!ok) chk("aw_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0;
  endtask

  task automatic accept_read(input logic [15:0] addr);
    bit ok = 0;
    @(posedge clk); #1;
    s_araddr = addr; s_arvalid = 1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (s_arready) ok = 1;
    end
    if (!ok) chk("ar_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    s_arvalid = 0;
  endtask

  task automatic wait_resp();
    bit ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if ((s_bvalid && s_bready) || (s_rvalid && s_rready)) ok = 1;
    end
    if (!ok) chk("resp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input bit want_rd);
    bit ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (want_rd ? s_arready : s_awready) ok = 1;
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {29'b0, s_awready, s_wready, s_arready}, 32'd0);
    chk({tag, "_valid"}, {30'b0, s_bvalid, s_rvalid}, 32'd0);
    chk({tag, "_mem"}, {30'b0, mem_req, mem_we}, 32'd0);
    chk({tag, "_addr"}, 32'(a_address), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rdata"}, s_rdata, 32'd0);
    chk({tag, "_resp"}, {28'b0, s_bresp, s_rresp}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0;
    rst_n = 0; s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 4'hF;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 1; s_rready = 1; mem_gnt = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1;

    // Collision right after reset: write first, then read
    @(posedge clk); #1;
    s_awaddr = 16'h0004; s_wdata = 32'h1111; s_awvalid = 1; s_wvalid = 1;
    s_araddr = 16'h0004; s_arvalid = 1;
    wr_q.push_back(mk_wr(13'd1, 16'h1111));
    rsp_q.push_back(mk_rsp(0, 2'b00, 32'h0));
    rsp_q.push_back(mk_rsp(1, 2'b00, 32'h1111));
    @(negedge clk);
    chk("coll1_wr_first", {30'b0, s_awready, s_arready}, 32'd2);
    @(posedge clk); #1;
    s_awvalid = 0; s_wvalid = 0;
    wait_ready(1);
    s_arvalid = 0;
    wait_resp();

    // Standalone write so the pointer has moved past the read
    wr_q.push_back(mk_wr(13'd2, 16'h2222));
    rsp_q.push_back(mk_rsp(0, 2'b00, 32'h0));
    accept_write(16'h0008, 32'h2222);
    wait_resp();

    // Repeat collision: read now wins
    @(posedge clk); #1;
    s_awaddr = 16'h000C; s_wdata = 32'h3333; s_awvalid = 1; s_wvalid = 1;
    s_araddr = 16'h0008; s_arvalid = 1;
    rsp_q.push_back(mk_rsp(1, 2'b00, 32'h2222));
    rsp_q.push_back(mk_rsp(0, 2'b00, 32'h0));
    wr_q.push_back(mk_wr(13'd3, 16'h3333));
    @(negedge clk);
    chk("coll2_rd_first", {30'b0, s_awready, s_arready}, 32'd1);
    @(posedge clk); #1;
    s_arvalid = 0;
    wait_ready(0);
    s_awvalid = 0; s_wvalid = 0;
    wait_resp();

    // Write 0x0ABC to byte 0x28 (word 10): we at +1, bvalid at +2
    wr_q.push_back(mk_wr(13'd10, 16'h0ABC));
    rsp_q.push_back(mk_rsp(0, 2'b00, 32'h0));
    accept_write(16'h0028, 32'h0000_0ABC);
    @(negedge clk);
    chk("wr_lat_we", {31'b0, mem_we}, 32'd1);
    chk("wr_lat_bvalid_early", {31'b0, s_bvalid}, 32'd0);
    @(negedge clk);
    chk("wr_lat_bvalid", {31'b0, s_bvalid}, 32'd1);
    @(posedge clk); #1;

    // Preload word 55, then read it back: grant at +1, rvalid at +3
    wr_q.push_back(mk_wr(13'd55, 16'h1234));
    rsp_q.push_back(mk_rsp(0, 2'b00, 32'h0));
    accept_write(16'h00DC, 32'h1234);
    wait_resp();
    rsp_q.push_back(mk_rsp(1, 2'b00, 32'h0000_1234));
    accept_read(16'h00DC);
    @(negedge clk);
    chk("rd_lat_req_addr", {18'b0, mem_req, a_address}, {18'b0, 1'b1, 13'd55});
    @(negedge clk);
    chk("rd_lat_rvalid_early", {31'b0, s_rvalid}, 32'd0);
    @(negedge clk);
    chk("rd_lat_rvalid", {31'b0, s_rvalid}, 32'd1);
    @(posedge clk); #1;

    // Grant withheld for 5 cycles on a write to word 100
    mem_gnt = 0;
    w0 = we_count;
    wr_q.push_back(mk_wr(13'd100, 16'h5A5A));
    rsp_q.push_back(mk_rsp(0, 2'b00, 32'h0));
    accept_write(16'h0190, 32'h5A5A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req_we", {30'b0, mem_req, mem_we}, 32'd2);
    end
    @(posedge clk); #1;
    mem_gnt = 1;
    @(negedge clk);
    chk("stall_we_on_gnt", {31'b0, mem_we}, 32'd1);
    wait_resp();
    chk("stall_one_write", 32'(we_count - w0), 32'd1);

    // Out-of-range write and read at word 8192
    r0 = req_count; w0 = we_count;
    rsp_q.push_back(mk_rsp(0, 2'b10, 32'h0));
    accept_write(16'h8000, 32'hFFFF);
    wait_resp();
    rsp_q.push_back(mk_rsp(1, 2'b10, 32'h0));
    accept_read(16'h8000);
    wait_resp();
    chk("oor_no_req", 32'(req_count - r0), 32'd0);
    chk("oor_no_we", 32'(we_count - w0), 32'd0);

    // bready held low: bvalid/bresp stable, no accept of a pending read
    s_bready = 0;
    wr_q.push_back(mk_wr(13'd5, 16'h0505));
    rsp_q.push_back(mk_rsp(0, 2'b00, 32'h0));
    accept_write(16'h0014, 32'h0505);
    s_araddr = 16'h0014; s_arvalid = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bhold_bvalid_resp", {29'b0, s_bvalid, s_bresp}, 32'h4);
      chk("bhold_no_accept", {30'b0, s_arready, s_awready}, 32'd0);
    end
    @(posedge clk); #1;
    s_arvalid = 0; s_bready = 1;
    wait_resp();

    // Async reset during RD_WAIT drops the read
    accept_read(16'h0014);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1;
    rsp_q.push_back(mk_rsp(1, 2'b00, 32'h0000_0505));
    accept_read(16'h0014);
    wait_resp();

    repeat (3) @(negedge clk);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
